// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
//
// Decoupling FIFO between the instruction fetch stage and the decode stage.
// It buffers {pc, inst, misalign} entries so that fetch and decode can stall
// independently. A redirect (flush) discards every buffered entry in the
// flush cycle itself. There is no bypass path, so a pushed entry reaches the
// head one cycle after the push.
//
// Parameters
//   DEPTH     number of entries (power of two, >= 2)
//   RESET_PC  value shown on out_pc while the queue is empty
//
// Ports
//   clk           single clock, rising edge
//   rst           synchronous reset, active-high (same effect as flush)
//   flush         redirect; empties the queue, blocks push/pop this cycle
//   in_valid      fetch presents an entry
//   in_ready      queue accepts an entry this cycle
//   in_pc         PC of the fetched instruction
//   in_inst       fetched instruction word
//   out_valid     head entry available to decode
//   out_ready     decode consumes the head this cycle
//   out_pc        PC of the head entry (RESET_PC when empty)
//   out_snpc      out_pc + 4, modulo 2^32
//   out_inst      head instruction word (nop when empty)
//   out_misalign  head entry was fetched from a non-word-aligned PC
//   count         current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_snpc,
  output logic [31:0]              out_inst,
  output logic                     out_misalign,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned   AW         = $clog2(DEPTH);
  localparam int unsigned   CW         = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [31:0]   NOP_INST   = 32'h0000_0013;

  // A fetch address is misaligned when it is not on a 4-byte boundary.
  function automatic logic pc_misaligned(input logic [31:0] pc);
    return |pc[1:0];
  endfunction

  // Entry storage. Never cleared: every output is gated by the occupancy.
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];
  logic          mis_mem_q  [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic          push;
  logic          pop;

  // Handshakes: reset and flush block both sides in the same cycle; a full
  // queue never accepts, even if the head is being popped this cycle.
  always_comb begin
    in_ready  = !rst && !flush && (count_q < FULL_COUNT);
    out_valid = !rst && !flush && (count_q != {CW{1'b0}});
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Next-state for pointers and occupancy; reset and flush both empty the queue.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (rst || flush) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      // Pointers are AW bits wide, so the increment wraps modulo DEPTH.
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State register for pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry write port; push is already suppressed during reset and flush.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= in_pc;
      inst_mem_q[wr_ptr_q] <= in_inst;
      mis_mem_q[wr_ptr_q]  <= pc_misaligned(in_pc);
    end
  end

  // Head view: read straight from storage, or the idle values when empty.
  // The head only moves on a pop, so data holds while decode stalls.
  always_comb begin
    out_pc       = RESET_PC;
    out_inst     = NOP_INST;
    out_misalign = 1'b0;
    if (count_q != {CW{1'b0}}) begin
      out_pc       = pc_mem_q[rd_ptr_q];
      out_inst     = inst_mem_q[rd_ptr_q];
      out_misalign = mis_mem_q[rd_ptr_q];
    end else begin
      out_pc       = RESET_PC;
      out_inst     = NOP_INST;
      out_misalign = 1'b0;
    end
    out_snpc = out_pc + 32'd4;
    count    = count_q;
  end

endmodule
